// File: rtl/exu_fp_sched.sv
// Scheduler that hands one IEEE-754 single-precision operation at a time to the
// add/mul/div units over a strobe/ack handshake. It has a watchdog and a flush path.
module exu_fp_sched #(
    parameter int TIMEOUT_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        flush,
    output logic        req_ready,
    output logic [31:0] unit_a,
    output logic [31:0] unit_b,
    output logic [2:0]  unit_a_stb,
    output logic [2:0]  unit_b_stb,
    output logic [2:0]  unit_z_ack,
    input  logic [2:0]  unit_a_ack,
    input  logic [2:0]  unit_b_ack,
    input  logic [2:0]  unit_z_stb,
    input  logic [31:0] z_add,
    input  logic [31:0] z_mul,
    input  logic [31:0] z_div,
    output logic        res_valid,
    output logic [31:0] res_data,
    output logic        res_err,
    output logic        fp_stall
);

    typedef enum logic [2:0] {
        IDLE,
        SEND_A,
        SEND_B,
        WAIT_Z,
        DONE
    } state_t;

    localparam logic [TIMEOUT_W-1:0] TMAX  = '1;
    localparam logic [TIMEOUT_W-1:0] TLAST = TMAX - 1'b1;

    state_t                 state_q, state_d;
    logic [2:0]             sel_q, sel_d;
    logic [31:0]            a_q, a_d;
    logic [31:0]            b_q, b_d;
    logic                   kill_q, kill_d;
    logic [TIMEOUT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]            res_data_q, res_data_d;
    logic                   res_err_q, res_err_d;

    logic                   a_ack;
    logic                   b_ack;
    logic                   z_stb;
    logic                   timeout;
    logic                   busy;
    logic [31:0]            z_sel;

    always_comb begin
        a_ack   = |(unit_a_ack & sel_q);
        b_ack   = |(unit_b_ack & sel_q);
        z_stb   = |(unit_z_stb & sel_q);
        busy    = (state_q == SEND_A) || (state_q == SEND_B) || (state_q == WAIT_Z);
        // The cycle in which the count reaches TLAST is the TMAX-th busy cycle.
        timeout = (cnt_q >= TLAST);
        case (sel_q)
            3'b001:  z_sel = z_add;
            3'b010:  z_sel = z_mul;
            3'b100:  z_sel = z_div;
            default: z_sel = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        a_d        = a_q;
        b_d        = b_q;
        kill_d     = kill_q;
        cnt_d      = cnt_q;
        res_data_d = res_data_q;
        res_err_d  = res_err_q;

        if (busy && (cnt_q != TMAX)) begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (req_valid && !flush) begin
                    a_d    = req_a;
                    b_d    = req_b;
                    kill_d = 1'b0;
                    cnt_d  = '0;
                    case (req_op)
                        2'b00:   sel_d = 3'b001;
                        2'b01:   sel_d = 3'b010;
                        2'b10:   sel_d = 3'b100;
                        default: sel_d = 3'b000;
                    endcase
                    if (req_op == 2'b11) begin
                        state_d    = DONE;
                        res_err_d  = 1'b1;
                        res_data_d = '0;
                    end else begin
                        state_d = SEND_A;
                    end
                end
            end

            SEND_A: begin
                if (a_ack) begin
                    state_d = SEND_B;
                    kill_d  = kill_q | flush;
                end else if (flush) begin
                    state_d = IDLE;
                end else if (timeout) begin
                    state_d = DONE;
                    if (!kill_q) begin
                        res_err_d  = 1'b1;
                        res_data_d = '0;
                    end
                end
            end

            SEND_B: begin
                kill_d = kill_q | flush;
                if (b_ack) begin
                    state_d = WAIT_Z;
                end else if (timeout) begin
                    state_d = DONE;
                    if (!kill_d) begin
                        res_err_d  = 1'b1;
                        res_data_d = '0;
                    end
                end
            end

            WAIT_Z: begin
                kill_d = kill_q | flush;
                if (z_stb) begin
                    state_d = DONE;
                    if (!kill_d) begin
                        res_err_d  = 1'b0;
                        res_data_d = z_sel;
                    end
                end else if (timeout) begin
                    state_d = DONE;
                    if (!kill_d) begin
                        res_err_d  = 1'b1;
                        res_data_d = '0;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
                kill_d  = 1'b0;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            kill_q     <= 1'b0;
            cnt_q      <= '0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            a_q        <= a_d;
            b_q        <= b_d;
            kill_q     <= kill_d;
            cnt_q      <= cnt_d;
            res_data_q <= res_data_d;
            res_err_q  <= res_err_d;
        end
    end

    assign req_ready  = (state_q == IDLE) && !flush;
    assign unit_a     = a_q;
    assign unit_b     = b_q;
    assign unit_a_stb = (state_q == SEND_A) ? sel_q : 3'b000;
    assign unit_b_stb = (state_q == SEND_B) ? sel_q : 3'b000;
    assign unit_z_ack = (state_q == WAIT_Z) ? sel_q : 3'b000;
    assign res_valid  = (state_q == DONE) && !kill_q && !flush;
    assign res_data   = res_data_q;
    assign res_err    = res_err_q;
    assign fp_stall   = (state_q != IDLE);

endmodule

// File: tb/tb_exu_fp_sched.sv
// Bench for exu_fp_sched. It runs directed and random transactions and compares them with a
// transaction-level timing model that works from phase lengths and the watchdog limit.
module tb_exu_fp_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        flush;
    logic        req_ready;
    logic [31:0] unit_a;
    logic [31:0] unit_b;
    logic [2:0]  unit_a_stb;
    logic [2:0]  unit_b_stb;
    logic [2:0]  unit_z_ack;
    logic [2:0]  unit_a_ack;
    logic [2:0]  unit_b_ack;
    logic [2:0]  unit_z_stb;
    logic [31:0] z_add;
    logic [31:0] z_mul;
    logic [31:0] z_div;
    logic        res_valid;
    logic [31:0] res_data;
    logic        res_err;
    logic        fp_stall;

    int total = 0;
    int bad   = 0;

    localparam int TMAX = 15;

    exu_fp_sched #(.TIMEOUT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .flush      (flush),
        .req_ready  (req_ready),
        .unit_a     (unit_a),
        .unit_b     (unit_b),
        .unit_a_stb (unit_a_stb),
        .unit_b_stb (unit_b_stb),
        .unit_z_ack (unit_z_ack),
        .unit_a_ack (unit_a_ack),
        .unit_b_ack (unit_b_ack),
        .unit_z_stb (unit_z_stb),
        .z_add      (z_add),
        .z_mul      (z_mul),
        .z_div      (z_div),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_err    (res_err),
        .fp_stall   (fp_stall)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, " ready"}, 32'(req_ready), 32'd1);
        checkOutput({tag, " stall"}, 32'(fp_stall), 32'd0);
        checkOutput({tag, " valid"}, 32'(res_valid), 32'd0);
        checkOutput({tag, " stbs"}, 32'({unit_a_stb, unit_b_stb, unit_z_ack}), 32'd0);
    endtask

    // One transaction: la/lb/lz are phase lengths in cycles, with the ack or z_stb in the last
    // cycle of each phase. fl is the cycle after accept that carries flush (0 means none).
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] zval, input int la, input int lb, input int lz,
                                 input int fl_in);
        logic [2:0]  sel;
        logic [31:0] exp_data;
        bit          illegal;
        bit          tmo;
        bit          aborted;
        bit          flushed;
        int          e1, e2, e3, endc, n, last, fl;

        sel     = (op == 2'd0) ? 3'b001 : (op == 2'd1) ? 3'b010 : (op == 2'd2) ? 3'b100 : 3'b000;
        illegal = (op == 2'd3);
        e1 = la;
        e2 = la + lb;
        e3 = la + lb + lz;
        tmo = 1'b0;
        if (illegal) begin
            endc = 0;
        end else if (e3 <= TMAX) begin
            endc = e3;
        end else begin
            // Acks win over the watchdog, so timeout lands on the first non-ack cycle from TMAX on.
            n = TMAX;
            while (n == e1 || n == e2) n++;
            endc = n;
            tmo  = (n != e3);
        end
        fl = fl_in;
        if (fl == endc && endc > 0) fl = endc + 1;
        aborted  = (fl >= 1) && (fl < endc) && (fl < e1);
        flushed  = (fl >= 1) && (fl <= endc + 1);
        last     = aborted ? fl : endc;
        exp_data = (illegal || tmo) ? 32'd0 : zval;

        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        flush     = 1'b0;
        #1;
        checkOutput("accept ready", 32'(req_ready), 32'd1);
        checkOutput("accept stall", 32'(fp_stall), 32'd0);
        @(posedge clk);

        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            req_valid  = 1'b0;
            req_a      = $urandom;
            req_b      = $urandom;
            req_op     = 2'($urandom);
            flush      = (c == fl);
            unit_a_ack = ((c == e1) ? sel : 3'b000) | (3'($urandom) & ~sel);
            unit_b_ack = ((c == e2) ? sel : 3'b000) | (3'($urandom) & ~sel);
            unit_z_stb = ((c == e3) ? sel : 3'b000) | (3'($urandom) & ~sel);
            z_add = $urandom;
            z_mul = $urandom;
            z_div = $urandom;
            if (c == e3) begin
                case (op)
                    2'd0:    z_add = zval;
                    2'd1:    z_mul = zval;
                    default: z_div = zval;
                endcase
            end
            #1;
            checkOutput("a_stb", 32'(unit_a_stb), 32'((c <= e1) ? sel : 3'b000));
            checkOutput("b_stb", 32'(unit_b_stb), 32'((c > e1 && c <= e2) ? sel : 3'b000));
            checkOutput("z_ack", 32'(unit_z_ack), 32'((c > e2 && c <= e3) ? sel : 3'b000));
            checkOutput("busy stall", 32'(fp_stall), 32'd1);
            checkOutput("busy ready", 32'(req_ready), 32'd0);
            checkOutput("busy valid", 32'(res_valid), 32'd0);
            checkOutput("unit_a", unit_a, a);
            checkOutput("unit_b", unit_b, b);
            @(posedge clk);
        end

        if (!aborted) begin
            @(negedge clk);
            req_valid  = 1'b0;
            flush      = (fl == endc + 1);
            unit_a_ack = 3'($urandom);
            unit_b_ack = 3'($urandom);
            unit_z_stb = 3'($urandom);
            #1;
            checkOutput("done stbs", 32'({unit_a_stb, unit_b_stb, unit_z_ack}), 32'd0);
            checkOutput("done stall", 32'(fp_stall), 32'd1);
            checkOutput("done valid", 32'(res_valid), 32'(!flushed));
            if (!flushed) begin
                checkOutput("res_err", 32'(res_err), 32'(illegal || tmo));
                checkOutput("res_data", res_data, exp_data);
            end
            @(posedge clk);
        end

        @(negedge clk);
        req_valid  = 1'b0;
        flush      = 1'b0;
        unit_a_ack = '0;
        unit_b_ack = '0;
        unit_z_stb = '0;
        #1;
        checkIdle("post");
        @(posedge clk);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_op     = '0;
        req_a      = '0;
        req_b      = '0;
        flush      = 1'b0;
        unit_a_ack = '0;
        unit_b_ack = '0;
        unit_z_stb = '0;
        z_add      = '0;
        z_mul      = '0;
        z_div      = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkIdle("reset");
        checkOutput("reset res_data", res_data, 32'd0);
        checkOutput("reset res_err", 32'(res_err), 32'd0);
        checkOutput("reset unit_a", unit_a, 32'd0);
        checkOutput("reset unit_b", unit_b, 32'd0);
        @(posedge clk);

        $display("[TB] directed: add with immediate acks");
        applyStimulus(2'd0, 32'h3F800000, 32'h40000000, 32'h40400000, 1, 1, 3, 0);
        $display("[TB] directed: illegal op");
        applyStimulus(2'd3, 32'h12345678, 32'h9ABCDEF0, 32'h0, 1, 1, 1, 0);
        $display("[TB] directed: div watchdog");
        applyStimulus(2'd2, 32'h40800000, 32'h40000000, 32'h0, 1, 40, 1, 0);
        $display("[TB] directed: mul flushed in WAIT_Z");
        applyStimulus(2'd1, 32'h40400000, 32'h40400000, 32'h41100000, 1, 1, 4, 3);
        $display("[TB] directed: flush in SEND_A without ack");
        applyStimulus(2'd0, 32'h3F000000, 32'h3F000000, 32'h3F800000, 4, 1, 1, 2);
        $display("[TB] directed: flush in DONE");
        applyStimulus(2'd1, 32'h40000000, 32'h40000000, 32'h40800000, 2, 1, 1, 5);

        $display("[TB] directed: reset during WAIT_Z");
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 2'd1;
        req_a     = 32'hDEADBEEF;
        req_b     = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        req_valid  = 1'b0;
        unit_a_ack = 3'b010;
        @(posedge clk);
        @(negedge clk);
        unit_a_ack = 3'b000;
        unit_b_ack = 3'b010;
        @(posedge clk);
        @(negedge clk);
        unit_b_ack = 3'b000;
        #1;
        checkOutput("rst pre z_ack", 32'(unit_z_ack), 32'd2);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkIdle("midrst");
        checkOutput("midrst res_data", res_data, 32'd0);
        checkOutput("midrst res_err", 32'(res_err), 32'd0);
        checkOutput("midrst unit_a", unit_a, 32'd0);
        checkOutput("midrst unit_b", unit_b, 32'd0);
        @(posedge clk);

        $display("[TB] random transactions");
        for (int i = 0; i < 60; i++) begin
            int fl;
            fl = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 12));
            applyStimulus(2'($urandom), $urandom, $urandom, $urandom,
                          int'($urandom_range(1, 7)), int'($urandom_range(1, 7)),
                          int'($urandom_range(1, 7)), fl);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
